uart_tx: RTL and testbench

- 8N1 UART transmitter with a small write FIFO. It is the transmit counterpart of the SoC UART receiver and sits inside the UART wrapper on the CPU data-bus side.
- The CPU writes bytes into the FIFO. The block serialises them LSB-first on txd at a fixed bit period, with status flags for software polling.

---
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// CPU-side write and status bundle of the UART transmitter.
// The master side is the bus and the slave side is the transmitter.
interface uart_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovr_clr;
  logic       full;
  logic       empty;
  logic       busy;
  logic       tx_done;
  logic       ovr;

  modport master (
    output wr_en, wr_data, ovr_clr,
    input  full, empty, busy, tx_done, ovr
  );

  modport slave (
    input  wr_en, wr_data, ovr_clr,
    output full, empty, busy, tx_done, ovr
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write FIFO.
// Frames are sent LSB-first, and each bit lasts CLK_DIV clocks.
module uart_tx #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 2
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     txd
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLK_DIV);
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_r, state_s;
  logic [BW-1:0]      baud_r, baud_s;
  logic [2:0]         bit_idx_r, bit_idx_s;
  logic [7:0]         shift_r, shift_s;
  logic               txd_r, txd_s;
  logic               busy_r;
  logic               tx_done_r, tx_done_s;
  logic               ovr_r, ovr_s;
  logic               full_r, empty_r;
  logic [FIFO_AW:0]   cnt_r, cnt_s;
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [7:0]         mem_r [DEPTH];
  logic               pop_s, wr_acc_s, ovr_set_s, bit_end_s;

  assign bit_end_s = (baud_r == BAUD_LAST);
  assign wr_acc_s  = bus.wr_en & ~full_r;
  assign ovr_set_s = bus.wr_en & full_r;

  // Frame sequencing: the STOP state pops the next byte so back-to-back frames have no gap.
  always_comb begin
    state_s   = state_r;
    baud_s    = baud_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    pop_s     = 1'b0;
    tx_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cnt_r != '0) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          baud_s  = '0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          baud_s    = '0;
          bit_idx_s = 3'd0;
          state_s   = DATA;
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_s    = '0;
          shift_s   = {1'b0, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          baud_s    = '0;
          tx_done_s = 1'b1;
          if (cnt_r != '0) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rd_ptr_r];
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      default: state_s = IDLE;
    endcase

    case (state_s)
      START:   txd_s = 1'b0;
      DATA:    txd_s = shift_s[0];
      default: txd_s = 1'b1;
    endcase
  end

  // FIFO occupancy and overrun flag; a same-cycle overrun beats the clear.
  always_comb begin
    case ({wr_acc_s, pop_s})
      2'b10:   cnt_s = cnt_r + (FIFO_AW + 1)'(1);
      2'b01:   cnt_s = cnt_r - (FIFO_AW + 1)'(1);
      default: cnt_s = cnt_r;
    endcase
    if (ovr_set_s) begin
      ovr_s = 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_s = 1'b0;
    end else begin
      ovr_s = ovr_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      tx_done_r <= 1'b0;
      ovr_r     <= 1'b0;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      cnt_r     <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      txd_r     <= txd_s;
      busy_r    <= (state_s != IDLE);
      tx_done_r <= tx_done_s;
      ovr_r     <= ovr_s;
      full_r    <= (cnt_s == CNT_FULL);
      empty_r   <= (cnt_s == '0);
      cnt_r     <= cnt_s;
      wr_ptr_r  <= wr_acc_s ? wr_ptr_r + FIFO_AW'(1) : wr_ptr_r;
      rd_ptr_r  <= pop_s ? rd_ptr_r + FIFO_AW'(1) : rd_ptr_r;
    end
  end

  // FIFO storage; the pointers guard validity, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  assign txd         = txd_r;
  assign bus.busy    = busy_r;
  assign bus.tx_done = tx_done_r;
  assign bus.ovr     = ovr_r;
  assign bus.full    = full_r;
  assign bus.empty   = empty_r;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: bytes are queued when written and checked when they are decoded from txd.
module tb_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam int HALF    = CLK_DIV / 2;

  logic clk = 1'b0;
  logic reset;
  logic txd;

  uart_tx_if bus();

  uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_done = 0;
  int fall_cyc = 0;
  logic [7:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Serial decoder: samples mid-bit on falling edges and pops the expected byte.
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] exp_b;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mon_active = 1'b0;
    end else begin
      if (bus.tx_done === 1'b1) begin
        check_val("done_latency", cyc - fall_cyc, FRAME);
        done_cnt++;
        last_done = cyc;
      end
      if (!mon_active) begin
        if (txd === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          fall_cyc   = cyc;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == HALF) begin
          check_val("start_bit", txd, 0);
        end else if (mon_cnt > CLK_DIV && mon_cnt < 9 * CLK_DIV && (mon_cnt % CLK_DIV) == HALF) begin
          mon_byte = {txd, mon_byte[7:1]};
        end else if (mon_cnt == 9 * CLK_DIV + HALF) begin
          check_val("stop_bit", txd, 1);
          check_val("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check_val("rx_byte", mon_byte, exp_b);
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (accept) exp_q.push_back(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int guard = 0;
    while (done_cnt < target && guard < 20 * FRAME) begin
      tick();
      guard++;
    end
    check_val(tag, done_cnt >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int d0;
    int t1;
    int f;
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovr_clr = 1'b0;

    // Reset state and idle line
    repeat (3) tick();
    check_val("rst_txd", txd, 1);
    check_val("rst_empty", bus.empty, 1);
    check_val("rst_full", bus.full, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_ovr", bus.ovr, 0);
    check_val("rst_done", bus.tx_done, 0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    check_val("idle_txd_high", bad, 0);

    // Single byte and start latency
    write_byte(8'h55, 1'b1);
    check_val("lat_pre_txd", txd, 1);
    check_val("lat_pre_empty", bus.empty, 0);
    tick();
    check_val("lat_start_txd", txd, 0);
    check_val("lat_busy", bus.busy, 1);
    wait_done(1, "single_done");
    check_val("single_busy_drop", bus.busy, 0);
    check_val("single_empty", bus.empty, 1);
    repeat (5) tick();
    check_val("single_one_pulse", done_cnt, 1);
    check_val("single_q_empty", exp_q.size(), 0);

    // Back-to-back frames
    d0 = done_cnt;
    write_byte(8'hA3, 1'b1);
    write_byte(8'h0F, 1'b1);
    wait_done(d0 + 1, "b2b_done1");
    t1 = last_done;
    wait_done(d0 + 2, "b2b_done2");
    check_val("b2b_spacing", last_done - t1, FRAME);
    check_val("b2b_q_empty", exp_q.size(), 0);
    repeat (3) tick();

    // Full, overrun, clear, then a write-while-full on the pop edge
    d0 = done_cnt;
    write_byte(8'h10, 1'b1);
    tick();
    check_val("ovf_frame_start", txd, 0);
    f = fall_cyc;
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    check_val("not_full_3", bus.full, 0);
    write_byte(8'h04, 1'b1);
    check_val("full_4", bus.full, 1);
    check_val("ovr_before", bus.ovr, 0);
    write_byte(8'h05, 1'b0);
    check_val("ovr_set", bus.ovr, 1);
    check_val("full_hold", bus.full, 1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check_val("ovr_cleared", bus.ovr, 0);
    while (cyc < f + FRAME - 1) tick();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h06;
    bus.ovr_clr = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
    bus.ovr_clr = 1'b0;
    check_val("sim_pop_edge", bus.tx_done, 1);
    check_val("sim_ovr_wins", bus.ovr, 1);
    check_val("sim_count3_full", bus.full, 0);
    check_val("sim_count3_empty", bus.empty, 0);
    wait_done(d0 + 5, "ovf_drain");
    check_val("ovf_q_empty", exp_q.size(), 0);
    check_val("ovf_end_empty", bus.empty, 1);
    repeat (3) tick();
    check_val("ovf_no_extra", done_cnt, d0 + 5);

    // Reset during data bit 3 of 0xFF
    write_byte(8'hFF, 1'b1);
    tick();
    f = fall_cyc;
    while (cyc < f + 4 * CLK_DIV + HALF + 1) tick();
    reset = 1'b0;
    #1;
    check_val("mid_rst_txd", txd, 1);
    check_val("mid_rst_empty", bus.empty, 1);
    check_val("mid_rst_busy", bus.busy, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    d0 = done_cnt;
    write_byte(8'h81, 1'b1);
    wait_done(d0 + 1, "post_rst_done");
    check_val("post_rst_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
